// File: rtl/conv_pkg.sv
// Shared constants, FSM state type and parity helper for the ConvCode chain
// (encoder here, Viterbi branch-metric stage elsewhere).
package conv_pkg;

  localparam int unsigned K_DEF  = 3;
  localparam int unsigned G0_DEF = 'o7;
  localparam int unsigned G1_DEF = 'o5;
  localparam int unsigned K_MAX  = 9;

  typedef enum logic {
    DATA,
    TAIL
  } enc_state_t;

  // Operands are zero-extended to K_MAX so one helper serves every legal K.
  function automatic logic parity(input logic [K_MAX-1:0] vec,
                                  input logic [K_MAX-1:0] poly);
    return ^(vec & poly);
  endfunction

endpackage

// File: rtl/conv_out_reg.sv
// One-deep valid/ready holding register for the encoder's {code_sig, code_last}.
module conv_out_reg #(
  parameter int unsigned W = 3
) (
  input  logic         clk_sig,
  input  logic         rst_sig,
  input  logic [W-1:0] load_data,
  input  logic         load_en,
  input  logic         take,
  output logic [W-1:0] hold_data,
  output logic         hold_valid,
  output logic         slot_free
);

  assign slot_free = !hold_valid || take;

  // The caller only asserts load_en while slot_free, so a load never overwrites a held word.
  always_ff @(posedge clk_sig or negedge rst_sig) begin
    if (!rst_sig) begin
      hold_data  <= '0;
      hold_valid <= 1'b0;
    end else if (load_en) begin
      hold_data  <= load_data;
      hold_valid <= 1'b1;
    end else if (take) begin
      hold_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/conv_encoder.sv
// Rate-1/2 feed-forward convolutional encoder with framed output.
// Define CONV_ENCODER_TAIL_EN to terminate every frame with K-1 zero tail bits.
module conv_encoder
  import conv_pkg::*;
#(
  parameter int unsigned K         = K_DEF,
  parameter int unsigned G0        = G0_DEF,
  parameter int unsigned G1        = G1_DEF,
  parameter int unsigned FRAME_LEN = 16
) (
  input  logic       clk_sig,
  input  logic       rst_sig,
  input  logic       bit_sig,
  input  logic       bit_valid,
  output logic       bit_ready,
  output logic [1:0] code_sig,
  output logic       code_valid,
  input  logic       code_ready,
  output logic       code_last
);

  localparam int unsigned CW = $clog2(FRAME_LEN + 1);
  localparam logic [K_MAX-1:0] G0_V = K_MAX'(G0);
  localparam logic [K_MAX-1:0] G1_V = K_MAX'(G1);

  logic [K-2:0]     sr;
  logic [CW-1:0]    bit_cnt;
  logic             slot_free;
  logic             enc_in;
  logic             enc_fire;
  logic             enc_last;
  logic             frame_end;
  logic [K_MAX-1:0] enc_vec;
  logic [2:0]       enc_word;
  logic [2:0]       out_word;

  assign frame_end = (bit_cnt == CW'(FRAME_LEN - 1));
  assign enc_vec   = K_MAX'({enc_in, sr});
  assign enc_word  = {parity(enc_vec, G0_V), parity(enc_vec, G1_V), enc_last};

`ifdef CONV_ENCODER_TAIL_EN
  localparam int unsigned TW = $clog2(K);

  enc_state_t    state;
  enc_state_t    state_next;
  logic [TW-1:0] tail_cnt;
  logic          tail_done;

  assign tail_done = (tail_cnt == TW'(K - 2));

  always_ff @(posedge clk_sig or negedge rst_sig) begin
    if (!rst_sig) state <= DATA;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      DATA:    if (bit_valid && bit_ready && frame_end) state_next = TAIL;
      TAIL:    if (slot_free && tail_done)              state_next = DATA;
      default: state_next = DATA;
    endcase
  end

  always_comb begin
    bit_ready = 1'b0;
    enc_in    = 1'b0;
    enc_fire  = 1'b0;
    enc_last  = 1'b0;
    case (state)
      DATA: begin
        bit_ready = slot_free && rst_sig;
        enc_in    = bit_sig;
        enc_fire  = bit_valid && slot_free && rst_sig;
      end
      TAIL: begin
        enc_fire = slot_free;
        enc_last = tail_done;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_sig or negedge rst_sig) begin
    if (!rst_sig)                       tail_cnt <= '0;
    else if (state == TAIL && slot_free) tail_cnt <= tail_done ? '0 : tail_cnt + 1'b1;
  end
`else
  assign bit_ready = slot_free && rst_sig;
  assign enc_in    = bit_sig;
  assign enc_fire  = bit_valid && bit_ready;
  assign enc_last  = frame_end;
`endif

  // Tail bits shift zeros through sr, so it is back at zero once the tail completes.
  always_ff @(posedge clk_sig or negedge rst_sig) begin
    if (!rst_sig) begin
      sr      <= '0;
      bit_cnt <= '0;
    end else if (enc_fire) begin
      sr <= {enc_in, sr[K-2:1]};
      if (bit_ready) bit_cnt <= frame_end ? '0 : bit_cnt + 1'b1;
    end
  end

  conv_out_reg #(.W(3)) u_out_reg (
    .clk_sig   (clk_sig),
    .rst_sig   (rst_sig),
    .load_data (enc_word),
    .load_en   (enc_fire),
    .take      (code_ready),
    .hold_data (out_word),
    .hold_valid(code_valid),
    .slot_free (slot_free)
  );

  assign {code_sig, code_last} = out_word;

endmodule

// File: doc/conv_encoder.md
Name: conv_encoder

Overview:
- Rate-1/2, feed-forward, non-recursive convolutional encoder.
- Sits directly downstream of the M-sequence generator: consumes one info bit per handshake and emits one 2-bit code symbol per handshake.
- Frames are FRAME_LEN info bits long. Each frame is terminated with K-1 zero tail bits, so the encoder state returns to zero at every frame boundary.
- Output goes to the channel/modulator model of the ConvCode chain.

Parameters:
- K, 3, constraint length; legal range 3-9.
- G0, 7, generator polynomial 0 (octal, K bits, MSB = current input tap); drives code_sig[1].
- G1, 5, generator polynomial 1 (octal, K bits, MSB = current input tap); drives code_sig[0].
- FRAME_LEN, 16, info bits per frame; legal range 1-65535.

Ports:
- clk_sig, in, 1, clock; all state changes on its rising edge.
- rst_sig, in, 1, asynchronous active-low reset.
- bit_sig, in, 1, info bit (e.g. the m_sig output of the M-sequence generator).
- bit_valid, in, 1, bit_sig is valid this cycle.
- bit_ready, out, 1, encoder accepts bit_sig this cycle.
- code_sig, out, 2, code symbol: [1] = G0 parity, [0] = G1 parity.
- code_valid, out, 1, code_sig holds a symbol.
- code_ready, in, 1, downstream accepts code_sig this cycle.
- code_last, out, 1, qualifies code_sig as the final symbol of the frame.

Behaviour:
- Reset (async, rst_sig=0):
  - state=DATA; shift register sr[K-2:0]=0; bit_cnt=0.
  - code_sig=2'b00, code_valid=0, code_last=0; bit_ready=0 while reset is asserted.
  - Reset mid-frame discards the partial frame and any held symbol. No tail is emitted.
- Encoding register: reg = {in, sr[K-2:0]}, where in is the current input bit and sr[K-2] is the most recent previous bit.
  - code_sig[1] = XOR-reduce(reg & G0).
  - code_sig[0] = XOR-reduce(reg & G1).
  - After each encode: sr <= {in, sr[K-2:1]}.
- Output register:
  - Single stage; slot_free = !code_valid || code_ready.
  - Accepting a bit loads code_sig/code_valid on the next edge, so latency is 1 cycle.
  - With code_ready tied high, throughput is 1 symbol/cycle.
  - code_sig and code_last are held stable while code_valid && !code_ready.
  - code_valid drops only after a handshake with no new symbol loaded.
- State DATA:
  - bit_ready = slot_free.
  - Transfer when bit_valid && bit_ready: encode bit_sig, bit_cnt++.
  - On transfer of info bit number FRAME_LEN (bit_cnt == FRAME_LEN-1): bit_cnt <= 0, go to TAIL.
- State TAIL:
  - bit_ready = 0; tail_cnt runs 0..K-2.
  - Each cycle with slot_free: encode in=0, tail_cnt++.
  - The symbol for tail_cnt == K-2 is loaded with code_last=1; next state is DATA with sr == 0.
- bit_valid is ignored whenever bit_ready=0. The encoder never drops or duplicates an input bit.
- A new frame's first bit may be accepted in the cycle after the last tail symbol is loaded.
- Counter widths: bit_cnt is clog2(FRAME_LEN+1) bits; tail_cnt is clog2(K) bits.

Optional Feature:
- Macro: CONV_ENCODER_TAIL_EN.
- Defined: tail termination as described above; a frame is FRAME_LEN+K-1 symbols.
- Undefined:
  - TAIL state is not built and sr is never cleared between frames (continuous stream).
  - code_last=1 on the FRAME_LEN-th symbol of each frame.
  - bit_ready = slot_free at all times after reset.

Decomposition:
- Shared package conv_pkg holds:
  - Default K, G0, G1 constants.
  - State encoding typedef (DATA, TAIL).
  - Parity function XOR-reduce(vec & poly), reused by the Viterbi decoder's branch-metric stage.
- Natural sub-module: conv_out_reg, a 1-deep valid/ready output register carrying {code_sig, code_last}.

Test Plan:
1. Basic encoding with tail (defaults, FRAME_LEN=4, code_ready=1):
   - Stimulus: bits 1,0,1,1.
   - Required: code_sig 11,10,00,01, then tail 01,11.
   - code_last=1 only on the 6th symbol; bit_ready=0 for the 2 tail cycles.
2. Backpressure:
   - Stimulus: same frame, code_ready held 0 for 3 cycles after the 2nd symbol appears.
   - Required: code_sig=10 held stable and bit_ready=0 for those 3 cycles; the full sequence is unchanged afterwards.
3. M-sequence source (FRAME_LEN=15, mseries M=4 on bit_sig, bit_valid=1):
   - Required: 17 symbols per frame, code_last on symbols 17 and 34.
   - Symbols must match a reference model bit-for-bit, and sr==0 at each frame start.
4. Reset mid-frame:
   - Stimulus: assert rst_sig after 2 bits while code_valid=1.
   - Required: code_valid, code_last and code_sig drop to 0 immediately (asynchronously).
   - After release, the first bit 1 encodes to 11 (sr was cleared).
5. Idle gaps:
   - Stimulus: bit_valid toggling 1,0,0,1 with bits 1,-,-,0.
   - Required: exactly 2 symbols 11,10; no symbol generated during gaps.
6. CONV_ENCODER_TAIL_EN undefined (FRAME_LEN=4):
   - Stimulus: 8 bits 1,0,1,1,1,0,1,1.
   - Required: symbols 11,10,00,01,10,01,00,01; code_last on symbols 4 and 8; bit_ready never deasserts.
